// File: rtl/airi5c_hasti_arbiter2_pkg.sv
// Shared hasti encodings and the data-phase owner type for the two-master arbiter.
package airi5c_hasti_arbiter2_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY = 1'b0;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_M0   = 2'b01,
        OWN_M1   = 2'b10
    } owner_e;

    // BUSY and IDLE never start a transfer; SEQ is treated like NONSEQ.
    function automatic logic is_request(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/airi5c_hasti_arb_slot.sv
// Per-master request detection and one-deep pending address-phase buffer.
module airi5c_hasti_arb_slot
    import airi5c_hasti_arbiter2_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [ADDR_W-1:0] haddr,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [1:0]        htrans,
    input  logic              hready,
    input  logic              grant,
    output logic              cand,
    output logic [ADDR_W-1:0] addr,
    output logic              write,
    output logic [2:0]        size,
    output logic              px
);

    logic              req;
    logic              px_d, px_q;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic              write_d, write_q;
    logic [2:0]        size_d, size_q;

    assign req   = is_request(htrans) & hready;
    assign cand  = px_q | req;
    assign addr  = px_q ? addr_q  : haddr;
    assign write = px_q ? write_q : hwrite;
    assign size  = px_q ? size_q  : hsize;
    assign px    = px_q;

    // A live request can only appear while nothing is pending, since hready is low then.
    always_comb begin
        px_d    = px_q;
        addr_d  = addr_q;
        write_d = write_q;
        size_d  = size_q;
        if (px_q) begin
            if (grant) begin
                px_d = 1'b0;
            end
        end else if (req && !grant) begin
            px_d    = 1'b1;
            addr_d  = haddr;
            write_d = hwrite;
            size_d  = hsize;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            px_q    <= 1'b0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
        end else begin
            px_q    <= px_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            size_q  <= size_d;
        end
    end

endmodule

// File: rtl/airi5c_hasti_arbiter2.sv
// Two-master AHB-Lite arbiter sharing one slave port; address phases that cannot
// be forwarded at once are buffered and the master is stalled through its hready.
module airi5c_hasti_arbiter2
    import airi5c_hasti_arbiter2_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [ADDR_W-1:0] m0_haddr,
    input  logic              m0_hwrite,
    input  logic [2:0]        m0_hsize,
    input  logic [1:0]        m0_htrans,
    input  logic [DATA_W-1:0] m0_hwdata,
    output logic [DATA_W-1:0] m0_hrdata,
    output logic              m0_hready,
    output logic              m0_hresp,
    input  logic [ADDR_W-1:0] m1_haddr,
    input  logic              m1_hwrite,
    input  logic [2:0]        m1_hsize,
    input  logic [1:0]        m1_htrans,
    input  logic [DATA_W-1:0] m1_hwdata,
    output logic [DATA_W-1:0] m1_hrdata,
    output logic              m1_hready,
    output logic              m1_hresp,
    output logic [ADDR_W-1:0] s_haddr,
    output logic              s_hwrite,
    output logic [2:0]        s_hsize,
    output logic [1:0]        s_htrans,
    output logic [DATA_W-1:0] s_hwdata,
    input  logic [DATA_W-1:0] s_hrdata,
    input  logic              s_hready,
    input  logic              s_hresp
);

    logic              arb_en;
    logic              cand0, cand1;
    logic              px0, px1;
    logic              grant0, grant1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic              write0, write1;
    logic [2:0]        size0, size1;
    owner_e            winner;
    owner_e            dp_owner_d, dp_owner_q;
    owner_e            last_grant_d, last_grant_q;

    // Gating with rst_ni keeps the slave bus idle while reset is held.
    assign arb_en = s_hready & rst_ni;

    airi5c_hasti_arb_slot #(.ADDR_W(ADDR_W)) u_slot0 (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .haddr  (m0_haddr),
        .hwrite (m0_hwrite),
        .hsize  (m0_hsize),
        .htrans (m0_htrans),
        .hready (m0_hready),
        .grant  (grant0),
        .cand   (cand0),
        .addr   (addr0),
        .write  (write0),
        .size   (size0),
        .px     (px0)
    );

    airi5c_hasti_arb_slot #(.ADDR_W(ADDR_W)) u_slot1 (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .haddr  (m1_haddr),
        .hwrite (m1_hwrite),
        .hsize  (m1_hsize),
        .htrans (m1_htrans),
        .hready (m1_hready),
        .grant  (grant1),
        .cand   (cand1),
        .addr   (addr1),
        .write  (write1),
        .size   (size1),
        .px     (px1)
    );

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (arb_en) begin
            if (cand0 && cand1) begin
                grant0 = (last_grant_q != OWN_M0);
                grant1 = (last_grant_q == OWN_M0);
            end else begin
                grant0 = cand0;
                grant1 = cand1;
            end
        end
    end

    always_comb begin
        winner = OWN_NONE;
        if (grant0) begin
            winner = OWN_M0;
        end else if (grant1) begin
            winner = OWN_M1;
        end
        dp_owner_d   = s_hready ? winner : dp_owner_q;
        last_grant_d = (winner == OWN_NONE) ? last_grant_q : winner;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dp_owner_q   <= OWN_NONE;
            last_grant_q <= OWN_M1;
        end else begin
            dp_owner_q   <= dp_owner_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        s_htrans = HTRANS_IDLE;
        s_haddr  = '0;
        s_hwrite = 1'b0;
        s_hsize  = '0;
        if (grant0) begin
            s_htrans = HTRANS_NONSEQ;
            s_haddr  = addr0;
            s_hwrite = write0;
            s_hsize  = size0;
        end else if (grant1) begin
            s_htrans = HTRANS_NONSEQ;
            s_haddr  = addr1;
            s_hwrite = write1;
            s_hsize  = size1;
        end
    end

    // Master hwdata is held stable during stalls, so a delayed data phase still sees valid data.
    assign s_hwdata  = (dp_owner_q == OWN_M0) ? m0_hwdata :
                       (dp_owner_q == OWN_M1) ? m1_hwdata : '0;

    assign m0_hready = (dp_owner_q == OWN_M0) ? s_hready : ~px0;
    assign m1_hready = (dp_owner_q == OWN_M1) ? s_hready : ~px1;
    assign m0_hresp  = (dp_owner_q == OWN_M0) ? s_hresp : HRESP_OKAY;
    assign m1_hresp  = (dp_owner_q == OWN_M1) ? s_hresp : HRESP_OKAY;
    assign m0_hrdata = s_hrdata;
    assign m1_hrdata = s_hrdata;

endmodule

// File: tb/tb_airi5c_hasti_arbiter2.sv
// Self-checking bench: directed scenarios with literal expectations, then random
// traffic compared every cycle against a behavioural arbiter model.
module tb_airi5c_hasti_arbiter2;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
    } req_t;

    logic        clk_i  = 1'b0;
    logic        rst_ni = 1'b0;

    logic [31:0] haddr  [2];
    logic        hwrite [2];
    logic [2:0]  hsize  [2];
    logic [1:0]  htrans [2];
    logic [31:0] hwdata [2];

    logic [31:0] m0_hrdata, m1_hrdata;
    logic        m0_hready, m1_hready, m0_hresp, m1_hresp;
    logic [31:0] s_haddr, s_hwdata, s_hrdata;
    logic        s_hwrite, s_hready, s_hresp;
    logic [2:0]  s_hsize;
    logic [1:0]  s_htrans;

    // Model state: pending request per master, data-phase owner (-1 = none), last winner.
    bit   pend_v [2];
    req_t pend_r [2];
    int   owner = -1;
    int   last  = 1;
    bit   exp_hready [2];
    bit   live [2];
    int   win = -1;

    int   total = 0;
    int   bad   = 0;
    int   err_state = 0;

    airi5c_hasti_arbiter2 #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .m0_haddr  (haddr[0]),
        .m0_hwrite (hwrite[0]),
        .m0_hsize  (hsize[0]),
        .m0_htrans (htrans[0]),
        .m0_hwdata (hwdata[0]),
        .m0_hrdata (m0_hrdata),
        .m0_hready (m0_hready),
        .m0_hresp  (m0_hresp),
        .m1_haddr  (haddr[1]),
        .m1_hwrite (hwrite[1]),
        .m1_hsize  (hsize[1]),
        .m1_htrans (htrans[1]),
        .m1_hwdata (hwdata[1]),
        .m1_hrdata (m1_hrdata),
        .m1_hready (m1_hready),
        .m1_hresp  (m1_hresp),
        .s_haddr   (s_haddr),
        .s_hwrite  (s_hwrite),
        .s_hsize   (s_hsize),
        .s_htrans  (s_htrans),
        .s_hwdata  (s_hwdata),
        .s_hrdata  (s_hrdata),
        .s_hready  (s_hready),
        .s_hresp   (s_hresp)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int x = 0; x < 2; x++) pend_v[x] = 1'b0;
        owner = -1;
        last  = 1;
    endtask

    // Who may talk to the slave this cycle, derived from the arbitration rules.
    task automatic modelEval();
        bit want [2];
        for (int x = 0; x < 2; x++) begin
            exp_hready[x] = (owner == x) ? s_hready : !pend_v[x];
            live[x]       = htrans[x][1] && exp_hready[x];
            want[x]       = pend_v[x] || live[x];
        end
        win = -1;
        if (rst_ni && s_hready) begin
            if (want[0] && want[1]) win = 1 - last;
            else if (want[0])       win = 0;
            else if (want[1])       win = 1;
        end
    endtask

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            modelReset();
        end else begin
            for (int x = 0; x < 2; x++) begin
                if (win == x) begin
                    pend_v[x] = 1'b0;
                end else if (live[x] && !pend_v[x]) begin
                    pend_v[x]       = 1'b1;
                    pend_r[x].addr  = haddr[x];
                    pend_r[x].write = hwrite[x];
                    pend_r[x].size  = hsize[x];
                end
            end
            if (s_hready) begin
                owner = win;
                if (win >= 0) last = win;
            end
        end
    end

    // Single compare process: every cycle, all outputs against the model.
    always @(negedge clk_i) begin
        logic [31:0] e_addr;
        logic        e_write;
        logic [2:0]  e_size;
        logic [31:0] e_wdata;
        modelEval();
        e_addr = '0; e_write = 1'b0; e_size = '0; e_wdata = '0;
        if (win >= 0) begin
            if (pend_v[win]) begin
                e_addr = pend_r[win].addr; e_write = pend_r[win].write; e_size = pend_r[win].size;
            end else begin
                e_addr = haddr[win]; e_write = hwrite[win]; e_size = hsize[win];
            end
        end
        if (owner >= 0) e_wdata = hwdata[owner];
        checkOutput("s_htrans", s_htrans, (win >= 0) ? 2'b10 : 2'b00);
        checkOutput("s_haddr", s_haddr, e_addr);
        checkOutput("s_hwrite", s_hwrite, e_write);
        checkOutput("s_hsize", s_hsize, e_size);
        checkOutput("s_hwdata", s_hwdata, e_wdata);
        checkOutput("m0_hready", m0_hready, exp_hready[0]);
        checkOutput("m1_hready", m1_hready, exp_hready[1]);
        checkOutput("m0_hresp", m0_hresp, (owner == 0) ? s_hresp : 1'b0);
        checkOutput("m1_hresp", m1_hresp, (owner == 1) ? s_hresp : 1'b0);
        checkOutput("m0_hrdata", m0_hrdata, s_hrdata);
        checkOutput("m1_hrdata", m1_hrdata, s_hrdata);
    end

    task automatic drive(input int x, input logic [1:0] tr, input logic [31:0] a,
                         input logic w, input logic [31:0] d);
        htrans[x] = tr; haddr[x] = a; hwrite[x] = w; hsize[x] = 3'b010; hwdata[x] = d;
    endtask

    task automatic slave(input logic rdy, input logic resp, input logic [31:0] rd);
        s_hready = rdy; s_hresp = resp; s_hrdata = rd;
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic at_check();
        @(negedge clk_i);
        #1;
    endtask

    // Random legal masters (hold everything while stalled) and a slave with waits and 2-cycle errors.
    task automatic applyStimulus();
        int r;
        for (int x = 0; x < 2; x++) begin
            if (exp_hready[x]) begin
                r = $urandom_range(0, 9);
                htrans[x] = (r < 5) ? 2'b10 : (r < 7) ? 2'b11 : (r < 8) ? 2'b01 : 2'b00;
                haddr[x]  = $urandom & 32'hFFFF_FFFC;
                hwrite[x] = 1'($urandom_range(0, 1));
                hsize[x]  = 3'($urandom_range(0, 2));
                hwdata[x] = $urandom;
            end
        end
        if (err_state == 1) begin
            s_hresp = 1'b1; s_hready = 1'b1; err_state = 0;
        end else if (owner >= 0 && $urandom_range(0, 11) == 0) begin
            s_hresp = 1'b1; s_hready = 1'b0; err_state = 1;
        end else begin
            s_hresp = 1'b0; s_hready = ($urandom_range(0, 3) != 0);
        end
        s_hrdata = $urandom;
    endtask

    initial begin
        drive(0, 2'b00, 32'h0, 1'b0, 32'h0);
        drive(1, 2'b00, 32'h0, 1'b0, 32'h0);
        slave(1'b1, 1'b0, 32'h0);
        repeat (3) next_cycle();
        at_check();
        checkOutput("rst_htrans", s_htrans, 2'b00);
        checkOutput("rst_haddr", s_haddr, 32'h0);
        checkOutput("rst_hwdata", s_hwdata, 32'h0);
        checkOutput("rst_m0_hready", m0_hready, 1'b1);
        checkOutput("rst_m1_hready", m1_hready, 1'b1);
        checkOutput("rst_m0_hresp", m0_hresp, 1'b0);

        // Simultaneous requests right after reset: M0 wins the first tie.
        next_cycle(); rst_ni = 1'b1;
        drive(0, 2'b10, 32'h20, 1'b1, 32'h0);
        drive(1, 2'b10, 32'h40, 1'b0, 32'h0);
        at_check();
        checkOutput("tie_haddr", s_haddr, 32'h20);
        checkOutput("tie_hwrite", s_hwrite, 1'b1);
        checkOutput("tie_m1_hready", m1_hready, 1'b1);
        next_cycle();
        drive(0, 2'b00, 32'h0, 1'b0, 32'h1234);
        drive(1, 2'b00, 32'h0, 1'b0, 32'h0);
        at_check();
        checkOutput("tie_m1_stall", m1_hready, 1'b0);
        checkOutput("tie_m1_haddr", s_haddr, 32'h40);
        checkOutput("tie_m1_htrans", s_htrans, 2'b10);
        checkOutput("tie_m0_wdata", s_hwdata, 32'h1234);
        next_cycle();
        at_check();
        checkOutput("tie_m1_done", m1_hready, 1'b1);
        checkOutput("tie_idle", s_htrans, 2'b00);

        // Lone M0 read with a zero-wait slave.
        next_cycle();
        drive(0, 2'b10, 32'h100, 1'b0, 32'h0);
        at_check();
        checkOutput("lone_htrans", s_htrans, 2'b10);
        checkOutput("lone_haddr", s_haddr, 32'h100);
        checkOutput("lone_m1_hready", m1_hready, 1'b1);
        next_cycle();
        drive(0, 2'b00, 32'h0, 1'b0, 32'h0);
        slave(1'b1, 1'b0, 32'hCAFE_0001);
        at_check();
        checkOutput("lone_rdata", m0_hrdata, 32'hCAFE_0001);
        checkOutput("lone_m0_hready", m0_hready, 1'b1);

        // M1 write with three slave wait states while M0 requests.
        next_cycle();
        drive(1, 2'b10, 32'hC000_0200, 1'b1, 32'h0);
        at_check();
        checkOutput("wait_haddr", s_haddr, 32'hC000_0200);
        next_cycle();
        drive(1, 2'b00, 32'h0, 1'b0, 32'h41);
        drive(0, 2'b10, 32'h300, 1'b0, 32'h0);
        slave(1'b0, 1'b0, 32'h0);
        at_check();
        checkOutput("wait_m1_hready1", m1_hready, 1'b0);
        checkOutput("wait_wdata", s_hwdata, 32'h41);
        checkOutput("wait_no_arb", s_htrans, 2'b00);
        checkOutput("wait_m0_accept", m0_hready, 1'b1);
        next_cycle();
        drive(0, 2'b00, 32'h0, 1'b0, 32'h0);
        at_check();
        checkOutput("wait_m0_stall", m0_hready, 1'b0);
        checkOutput("wait_m1_hready2", m1_hready, 1'b0);
        next_cycle();
        at_check();
        checkOutput("wait_m1_hready3", m1_hready, 1'b0);
        next_cycle();
        slave(1'b1, 1'b0, 32'h0);
        at_check();
        checkOutput("wait_m1_release", m1_hready, 1'b1);
        checkOutput("wait_m0_fwd", s_haddr, 32'h300);
        checkOutput("wait_m0_htrans", s_htrans, 2'b10);
        checkOutput("wait_m0_still", m0_hready, 1'b0);
        next_cycle();
        at_check();
        checkOutput("wait_m0_done", m0_hready, 1'b1);

        // Two-cycle ERROR to M0 while M1 gets buffered.
        next_cycle();
        drive(0, 2'b10, 32'h400, 1'b0, 32'h0);
        at_check();
        checkOutput("err_haddr", s_haddr, 32'h400);
        next_cycle();
        drive(0, 2'b00, 32'h0, 1'b0, 32'h0);
        drive(1, 2'b10, 32'h500, 1'b0, 32'h0);
        slave(1'b0, 1'b1, 32'h0);
        at_check();
        checkOutput("err1_m0_hresp", m0_hresp, 1'b1);
        checkOutput("err1_m1_hresp", m1_hresp, 1'b0);
        checkOutput("err1_m0_hready", m0_hready, 1'b0);
        next_cycle();
        drive(1, 2'b00, 32'h0, 1'b0, 32'h0);
        slave(1'b1, 1'b1, 32'h0);
        at_check();
        checkOutput("err2_m0_hresp", m0_hresp, 1'b1);
        checkOutput("err2_m0_hready", m0_hready, 1'b1);
        checkOutput("err2_m1_stall", m1_hready, 1'b0);
        checkOutput("err2_m1_fwd", s_haddr, 32'h500);
        next_cycle();
        slave(1'b1, 1'b0, 32'h0);
        at_check();
        checkOutput("err3_m1_hready", m1_hready, 1'b1);
        checkOutput("err3_m0_hresp", m0_hresp, 1'b0);

        // Reset while M1 is pending and M0 owns a waited data phase.
        next_cycle();
        drive(0, 2'b10, 32'h600, 1'b0, 32'h0);
        at_check();
        checkOutput("rst2_fwd", s_haddr, 32'h600);
        next_cycle();
        drive(0, 2'b00, 32'h0, 1'b0, 32'h0);
        drive(1, 2'b10, 32'h700, 1'b0, 32'h0);
        slave(1'b0, 1'b0, 32'h0);
        at_check();
        checkOutput("rst2_m0_wait", m0_hready, 1'b0);
        next_cycle();
        drive(1, 2'b00, 32'h0, 1'b0, 32'h0);
        rst_ni = 1'b0;
        at_check();
        checkOutput("rst2_htrans", s_htrans, 2'b00);
        checkOutput("rst2_haddr", s_haddr, 32'h0);
        checkOutput("rst2_m0_hready", m0_hready, 1'b1);
        checkOutput("rst2_m1_hready", m1_hready, 1'b1);
        checkOutput("rst2_hwdata", s_hwdata, 32'h0);
        next_cycle();
        rst_ni = 1'b1;
        slave(1'b1, 1'b0, 32'h0);
        drive(1, 2'b10, 32'h800, 1'b1, 32'h0);
        at_check();
        checkOutput("rst2_m1_first", s_haddr, 32'h800);
        checkOutput("rst2_m1_htrans", s_htrans, 2'b10);
        next_cycle();
        drive(1, 2'b00, 32'h0, 1'b0, 32'h99);
        at_check();
        checkOutput("rst2_m1_wdata", s_hwdata, 32'h99);
        checkOutput("rst2_m1_hready", m1_hready, 1'b1);

        // Random traffic with one mid-run reset.
        for (int c = 0; c < 2000; c++) begin
            next_cycle();
            if (c == 1000) rst_ni = 1'b0;
            if (c == 1003) rst_ni = 1'b1;
            applyStimulus();
        end
        at_check();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
